// File: rtl/uzed_io_pkg.sv
// Shared definitions for the UZED board I/O blocks: event codes, event record
// layout, clock constants and a constant-evaluable clog2.
package uzed_io_pkg;

   localparam logic [1:0] EVT_RISE = 2'd0;
   localparam logic [1:0] EVT_FALL = 2'd1;
   localparam logic [1:0] EVT_LONG = 2'd2;

   localparam int CLK_600_HZ = 600000000;
   localparam int CYC_PER_MS = 600000;

   typedef logic [1:0] evt_type_t;

   typedef struct packed {
      logic [3:0] idx;
      evt_type_t  typ;
   } event_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/uzed_debounce_chan.sv
// One input channel: synchronizer, optional inversion, debounce counter and
// long-press hold counter driven by a shared tick.
module uzed_debounce_chan
   import uzed_io_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter logic INVERT          = 1'b0,
   parameter int   DEBOUNCE_CYCLES = 600000,
   parameter int   LONG_TICKS      = 500
) (
   input  logic clk_600,
   input  logic RESET,
   input  logic raw_in,
   input  logic tick,
   output logic state,
   output logic rise,
   output logic fall,
   output logic long_press
);

   localparam int CNT_W  = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = (clog2(LONG_TICKS + 2) < 1) ? 1 : clog2(LONG_TICKS + 2);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_ARM = HOLD_W'(LONG_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(LONG_TICKS + 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic                   state_q, state_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   long_q, long_d;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1] ^ INVERT;

   // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], raw_in};
      cnt_d   = cnt_q;
      state_d = state_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (s == state_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         state_d = s;
         rise_d  = s;
         fall_d  = ~s;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // The first tick after a press lands mid-interval and only opens the window;
   // LONG_TICKS full intervals must follow, so the hold is never shorter than nominal.
   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (!state_q) begin
         hold_d = '0;
      end else if (tick && (hold_q != HOLD_SAT)) begin
         hold_d = hold_q + HOLD_W'(1);
         long_d = (hold_q == HOLD_ARM);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_600 or posedge RESET) begin
      if (RESET) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         state_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         state_q <= state_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         long_q  <= long_d;
      end
   end

   assign state      = state_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign long_press = long_q;

endmodule

// File: rtl/uzed_button_debounce.sv
// Debounced button/DIP input block: per-channel debounce and long-press
// detection feeding a prioritized valid/ready event register.
module uzed_button_debounce
   import uzed_io_pkg::*;
#(
   parameter int                  N_INPUTS        = 8,
   parameter int                  SYNC_STAGES     = 2,
   parameter logic [N_INPUTS-1:0] INVERT_MASK     = '0,
   parameter int                  DEBOUNCE_CYCLES = CYC_PER_MS,
   parameter int                  TICK_CYCLES     = CYC_PER_MS,
   parameter int                  LONG_TICKS      = 500
) (
   input  logic                clk_600,
   input  logic                RESET,
   input  logic [N_INPUTS-1:0] btn_raw,
   output logic [N_INPUTS-1:0] btn_state,
   output logic [N_INPUTS-1:0] btn_rise,
   output logic [N_INPUTS-1:0] btn_fall,
   output logic [N_INPUTS-1:0] btn_long,
   output logic                event_valid,
   input  logic                event_ready,
   output logic [3:0]          event_idx,
   output logic [1:0]          event_type,
   output logic                event_overflow,
   input  logic                overflow_clr
);

   localparam int TICK_W = (clog2(TICK_CYCLES) < 1) ? 1 : clog2(TICK_CYCLES);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

   logic [TICK_W-1:0]   pres_q, pres_d;
   logic                tick_q, tick_d;
   logic [N_INPUTS-1:0] pend_rise_q, pend_rise_d;
   logic [N_INPUTS-1:0] pend_long_q, pend_long_d;
   logic [N_INPUTS-1:0] pend_fall_q, pend_fall_d;
   logic [N_INPUTS-1:0] eff_rise, eff_long, eff_fall;
   logic [N_INPUTS-1:0] ld_rise, ld_long, ld_fall;
   logic                valid_q, valid_d;
   logic                ovf_q, ovf_d;
   logic                load, found;
   event_t              evt_q, evt_d;

   for (genvar g = 0; g < N_INPUTS; g++) begin : g_chan
      uzed_debounce_chan #(
         .SYNC_STAGES     (SYNC_STAGES),
         .INVERT          (INVERT_MASK[g]),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_TICKS      (LONG_TICKS)
      ) u_chan (
         .clk_600    (clk_600),
         .RESET      (RESET),
         .raw_in     (btn_raw[g]),
         .tick       (tick_q),
         .state      (btn_state[g]),
         .rise       (btn_rise[g]),
         .fall       (btn_fall[g]),
         .long_press (btn_long[g])
      );
   end

   always_comb begin
      tick_d = (pres_q == TICK_LAST);
      pres_d = tick_d ? '0 : pres_q + TICK_W'(1);
   end

   // Pulses arriving this cycle are eligible for loading immediately, so an
   // idle register presents an event the cycle after its pulse.
   always_comb begin
      eff_rise = pend_rise_q | btn_rise;
      eff_long = pend_long_q | btn_long;
      eff_fall = pend_fall_q | btn_fall;
      load     = !valid_q || event_ready;
      ld_rise  = '0;
      ld_long  = '0;
      ld_fall  = '0;
      found    = 1'b0;
      valid_d  = valid_q;
      evt_d    = evt_q;
      if (load) begin
         valid_d = 1'b0;
         for (int i = 0; i < N_INPUTS; i++) begin
            if (!found && (eff_rise[i] || eff_long[i] || eff_fall[i])) begin
               found     = 1'b1;
               valid_d   = 1'b1;
               evt_d.idx = 4'(i);
               if (eff_rise[i]) begin
                  evt_d.typ  = EVT_RISE;
                  ld_rise[i] = 1'b1;
               end else if (eff_long[i]) begin
                  evt_d.typ  = EVT_LONG;
                  ld_long[i] = 1'b1;
               end else begin
                  evt_d.typ  = EVT_FALL;
                  ld_fall[i] = 1'b1;
               end
            end
         end
      end
   end

   // A loaded bit survives only when an already-pending event is taken and a
   // fresh pulse lands on the same edge; a pulse onto a bit that stays set is dropped.
   always_comb begin
      pend_rise_d = (eff_rise & ~ld_rise) | (pend_rise_q & btn_rise);
      pend_long_d = (eff_long & ~ld_long) | (pend_long_q & btn_long);
      pend_fall_d = (eff_fall & ~ld_fall) | (pend_fall_q & btn_fall);
      ovf_d       = (|(pend_rise_q & btn_rise & ~ld_rise))
                  | (|(pend_long_q & btn_long & ~ld_long))
                  | (|(pend_fall_q & btn_fall & ~ld_fall))
                  | (ovf_q && !overflow_clr);
   end

   always_ff @(posedge clk_600 or posedge RESET) begin
      if (RESET) begin
         pres_q      <= '0;
         tick_q      <= 1'b0;
         pend_rise_q <= '0;
         pend_long_q <= '0;
         pend_fall_q <= '0;
         valid_q     <= 1'b0;
         evt_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         pres_q      <= pres_d;
         tick_q      <= tick_d;
         pend_rise_q <= pend_rise_d;
         pend_long_q <= pend_long_d;
         pend_fall_q <= pend_fall_d;
         valid_q     <= valid_d;
         evt_q       <= evt_d;
         ovf_q       <= ovf_d;
      end
   end

   assign event_valid    = valid_q;
   assign event_idx      = evt_q.idx;
   assign event_type     = evt_q.typ;
   assign event_overflow = ovf_q;

endmodule
